// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-port round-robin arbiter for the Manta register bus
// Optional build macro: ARB_STATS_EN adds grant_cnt0, grant_cnt1 and timeout_cnt.
`timescale 1ns/1ps

module bus_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_rw,
  input  logic                  req0_valid,
  output logic                  req0_ready,

  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_rw,
  input  logic                  req1_valid,
  output logic                  req1_ready,

  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_err,
  output logic                  rsp0_valid,

  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_err,
  output logic                  rsp1_valid,

  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  output logic                  bus_rw_o,
  output logic                  bus_valid_o,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  input  logic                  bus_valid_i
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]           grant_cnt0,
  output logic [31:0]           grant_cnt1,
  output logic [31:0]           timeout_cnt
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // The wait counter only ever needs to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic             last_grant;
  logic             grant_port;
  logic [CNT_W-1:0] wait_cnt;

  logic             sel_valid;
  logic             sel_port;
  logic             arb_open;
  logic             handshake;
  logic             timeout_hit;
  logic             rsp_fire;

  // Round-robin selection: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    sel_valid = req0_valid | req1_valid;
    sel_port  = 1'b0;
    if (req0_valid && req1_valid) begin
      sel_port = ~last_grant;
    end else if (req1_valid) begin
      sel_port = 1'b1;
    end
  end

  // Arbitration is closed during the response pulse so the next handshake lands one cycle later.
  assign arb_open    = (state == ST_IDLE) && !rsp0_valid && !rsp1_valid;
  assign handshake   = arb_open && sel_valid;
  assign req0_ready  = arb_open && sel_valid && !sel_port;
  assign req1_ready  = arb_open && sel_valid &&  sel_port;

  // A real response arriving in the last wait cycle beats the timeout.
  assign timeout_hit = (state == ST_WAIT) && !bus_valid_i && (wait_cnt == CNT_LAST);
  assign rsp_fire    = (state == ST_WAIT) && (bus_valid_i || timeout_hit);

  assign bus_valid_o = (state == ST_ISSUE);

  // Transaction sequencer: IDLE -> ISSUE -> WAIT -> IDLE, with grant history and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant_port <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            grant_port <= sel_port;
            last_grant <= sel_port;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rsp_fire) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture the granted request; the bus fields stay stable until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr_o <= '0;
      bus_data_o <= '0;
      bus_rw_o   <= 1'b0;
    end else if (handshake) begin
      bus_addr_o <= sel_port ? req1_addr : req0_addr;
      bus_data_o <= sel_port ? req1_data : req0_data;
      bus_rw_o   <= sel_port ? req1_rw   : req0_rw;
    end
  end

  // Registered one-cycle response steered to the granted port; idle fields read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
      if (rsp_fire) begin
        if (grant_port) begin
          rsp1_valid <= 1'b1;
          rsp1_data  <= bus_valid_i ? bus_data_i : '0;
          rsp1_err   <= !bus_valid_i;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_data  <= bus_valid_i ? bus_data_i : '0;
          rsp0_err   <= !bus_valid_i;
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  // Free-running grant and timeout statistics, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0  <= '0;
      grant_cnt1  <= '0;
      timeout_cnt <= '0;
    end else begin
      if (handshake && !sel_port) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (handshake &&  sel_port) grant_cnt1 <= grant_cnt1 + 32'd1;
      if (timeout_hit)            timeout_cnt <= timeout_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard testbench for bus_arbiter
`timescale 1ns/1ps

module tb_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_rw, req1_rw, req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic          rsp0_err, rsp1_err, rsp0_valid, rsp1_valid;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_data_o;
  logic          bus_rw_o, bus_valid_o;
  logic [DW-1:0] bus_data_i;
  logic          bus_valid_i;
`ifdef ARB_STATS_EN
  logic [31:0]   grant_cnt0, grant_cnt1, timeout_cnt;
`endif

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_addr(req0_addr), .req0_data(req0_data), .req0_rw(req0_rw),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_addr(req1_addr), .req1_data(req1_data), .req1_rw(req1_rw),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .rsp0_data(rsp0_data), .rsp0_err(rsp0_err), .rsp0_valid(rsp0_valid),
    .rsp1_data(rsp1_data), .rsp1_err(rsp1_err), .rsp1_valid(rsp1_valid),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_rw_o(bus_rw_o),
    .bus_valid_o(bus_valid_o), .bus_data_i(bus_data_i), .bus_valid_i(bus_valid_i)
`ifdef ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .timeout_cnt(timeout_cnt)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rw;
  } bus_exp_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
    logic          err;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  int       checks = 0;
  int       errors = 0;

  logic          core_mute  = 1'b0;
  logic [DW-1:0] core_rdata = 16'hBEEF;
  int            core_lat   = 3;

  logic [DW-1:0] resp_d;
  bus_exp_t      be;
  rsp_exp_t      re;
  logic          got_port;
  logic [DW-1:0] got_data;
  logic          got_err;

  task automatic start_txn(input logic port, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic rw, input logic mute, input logic exp_rsp);
    int n;
    core_mute = mute;
    bus_q.push_back('{addr: a, data: d, rw: rw});
    if (exp_rsp)
      rsp_q.push_back('{port: port, data: mute ? 16'h0000 : (rw ? d : core_rdata), err: mute});
    if (port) begin
      req1_addr = a; req1_data = d; req1_rw = rw; req1_valid = 1'b1;
    end else begin
      req0_addr = a; req0_data = d; req0_rw = rw; req0_valid = 1'b1;
    end
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) break;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL handshake port%0d: ready stayed 0 for %0d cycles, required 1", port, n);
    end else begin
      @(posedge clk);
      #1;
    end
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_q.size() != 0 || bus_q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: %0d rsp / %0d bus expectations pending, required 0",
               rsp_q.size(), bus_q.size());
      rsp_q.delete();
      bus_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic one_txn(input logic port, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic rw, input logic mute);
    start_txn(port, a, d, rw, mute, 1'b1);
    wait_done(60);
    core_mute = 1'b0;
  endtask

  // Cycles from the bus issue pulse to the response pulse.
  task automatic rsp_latency(output int n);
    n = 0;
    @(negedge clk);
    while (!(rsp0_valid || rsp1_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({req0_ready, req1_ready, rsp0_data, rsp1_data, rsp0_err, rsp1_err, rsp0_valid, rsp1_valid,
         bus_addr_o, bus_data_o, bus_rw_o, bus_valid_o} !== '0) begin
      errors++;
      $display("FAIL %s: outputs not all zero (bus_addr=%h bus_valid=%b rsp0_valid=%b rsp1_valid=%b ready=%b%b), required 0",
               tag, bus_addr_o, bus_valid_o, rsp0_valid, rsp1_valid, req0_ready, req1_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset_released");
    @(posedge clk);
    #1;
  endtask

  task automatic test_tie;
    int n;
    logic [1:0] exp_rdy;
    for (int i = 0; i < 4; i++) begin
      bus_q.push_back('{addr: (i % 2 == 0) ? 16'h0001 : 16'h0002, data: 16'h0000, rw: 1'b0});
      rsp_q.push_back('{port: (i % 2 == 1), data: core_rdata, err: 1'b0});
    end
    req0_addr = 16'h0001; req0_data = 16'h0000; req0_rw = 1'b0; req0_valid = 1'b1;
    req1_addr = 16'h0002; req1_data = 16'h0000; req1_rw = 1'b0; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (n < 50) begin
        @(negedge clk);
        if (req0_ready || req1_ready) break;
        n++;
      end
      checks++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        errors++;
        $display("FAIL tie_grant%0d: ready1/0=%b, required %b", i, {req1_ready, req0_ready}, exp_rdy);
      end
      @(posedge clk);
      #1;
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    wait_done(100);
  endtask

  task automatic test_single_read;
    int n;
    start_txn(1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1);
    rsp_latency(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL read_latency: %0d cycles issue->rsp, required 4", n);
    end
    wait_done(30);
  endtask

  task automatic test_write;
    one_txn(1'b1, 16'h0010, 16'h1234, 1'b1, 1'b0);
  endtask

  task automatic test_timeout;
    int n;
    start_txn(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b1);
    rsp_latency(n);
    checks++;
    if (n !== TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: %0d cycles issue->rsp, required %0d", n, TO + 1);
    end
    wait_done(30);
    core_mute = 1'b0;
    one_txn(1'b1, 16'h0021, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_stray;
    bus_data_i  = 16'h5555;
    bus_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus_valid_i = 1'b0;
    bus_data_i  = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp0_valid || rsp1_valid) begin
        errors++;
        $display("FAIL stray_rsp%0d: rsp valid=%b%b, required 00", i, rsp1_valid, rsp0_valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort;
    start_txn(1'b0, 16'h0030, 16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("abort_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    core_mute = 1'b0;
    wait_done(10);
    one_txn(1'b0, 16'h0031, 16'h0000, 1'b0, 1'b0);
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if ({grant_cnt0, grant_cnt1, timeout_cnt} !== '0) begin
      errors++;
      $display("FAIL stats_reset: %0d/%0d/%0d, required 0/0/0", grant_cnt0, grant_cnt1, timeout_cnt);
    end
    one_txn(1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0);
    one_txn(1'b1, 16'h0041, 16'h0000, 1'b0, 1'b0);
    one_txn(1'b0, 16'h0042, 16'h0000, 1'b0, 1'b1);
    one_txn(1'b1, 16'h0043, 16'h00AA, 1'b1, 1'b0);
    one_txn(1'b0, 16'h0044, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (grant_cnt0 !== 32'd3 || grant_cnt1 !== 32'd2 || timeout_cnt !== 32'd1) begin
      errors++;
      $display("FAIL stats_counts: grant0=%0d grant1=%0d timeout=%0d, required 3/2/1",
               grant_cnt0, grant_cnt1, timeout_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req0_addr = '0; req0_data = '0; req0_rw = 1'b0; req0_valid = 1'b0;
    req1_addr = '0; req1_data = '0; req1_rw = 1'b0; req1_valid = 1'b0;
    bus_data_i = '0; bus_valid_i = 1'b0;

    fork
      // Bench core: answers each issue after core_lat cycles; writes echo their data.
      begin
        forever begin
          @(negedge clk);
          if (bus_valid_o && !core_mute) begin
            resp_d = bus_rw_o ? bus_data_o : core_rdata;
            repeat (core_lat) @(posedge clk);
            #1;
            bus_valid_i = 1'b1;
            bus_data_i  = resp_d;
            @(posedge clk);
            #1;
            bus_valid_i = 1'b0;
            bus_data_i  = '0;
          end
        end
      end
      // Bus issue monitor.
      begin
        forever begin
          @(negedge clk);
          if (bus_valid_o) begin
            checks++;
            if (bus_q.size() == 0) begin
              errors++;
              $display("FAIL bus_unexpected: issue addr=%h, required no issue", bus_addr_o);
            end else begin
              be = bus_q.pop_front();
              if ({bus_addr_o, bus_data_o, bus_rw_o} !== {be.addr, be.data, be.rw}) begin
                errors++;
                $display("FAIL bus_issue: addr=%h data=%h rw=%b, required addr=%h data=%h rw=%b",
                         bus_addr_o, bus_data_o, bus_rw_o, be.addr, be.data, be.rw);
              end
            end
          end
        end
      end
      // Response monitor.
      begin
        forever begin
          @(negedge clk);
          if (rsp0_valid || rsp1_valid) begin
            checks++;
            got_port = rsp1_valid;
            got_data = rsp1_valid ? rsp1_data : rsp0_data;
            got_err  = rsp1_valid ? rsp1_err  : rsp0_err;
            if (rsp0_valid && rsp1_valid) begin
              errors++;
              $display("FAIL rsp_both: rsp0_valid=1 rsp1_valid=1, required one");
            end else if (rsp_q.size() == 0) begin
              errors++;
              $display("FAIL rsp_unexpected: port%0d data=%h err=%b, required none", got_port, got_data, got_err);
            end else begin
              re = rsp_q.pop_front();
              if ({got_port, got_data, got_err} !== {re.port, re.data, re.err}) begin
                errors++;
                $display("FAIL rsp: port%0d data=%h err=%b, required port%0d data=%h err=%b",
                         got_port, got_data, got_err, re.port, re.data, re.err);
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_tie();
    test_single_read();
    test_write();
    test_timeout();
    test_stray();
    test_reset_abort();
`ifdef ARB_STATS_EN
    test_stats();
`endif

    repeat (5) @(negedge clk);
    checks++;
    if (bus_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL leftovers: %0d bus / %0d rsp expectations pending, required 0", bus_q.size(), rsp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one Manta internal register bus (16-bit addr, 16-bit data, rw, valid pulse) between two requesters, e.g. the Ethernet bridge and a UART bridge.
- Sits between the bridges' request/response ports and the head/tail of the core chain (lut_mem, io cores).
- Round-robin grant with one outstanding transaction at a time.
- Responses are routed back to the issuing requester; a timeout recovers from lost responses.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 16, bus data width.
- TIMEOUT_CYCLES, 255, cycles to wait in WAIT before forcing an error response; must be ≥ 1.

Ports:
- clk  in  1  bus clock (50 MHz ethernet clock domain).
- rst_n  in  1  asynchronous active-low reset.
- req0_addr / req1_addr  in  ADDR_WIDTH  requester address.
- req0_data / req1_data  in  DATA_WIDTH  write data.
- req0_rw / req1_rw  in  1  1 = write, 0 = read.
- req0_valid / req1_valid  in  1  request offered.
- req0_ready / req1_ready  out  1  request accepted when valid & ready.
- rsp0_data / rsp1_data  out  DATA_WIDTH  returned data.
- rsp0_err / rsp1_err  out  1  response produced by timeout.
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse.
- bus_addr_o  out  ADDR_WIDTH  address to core chain.
- bus_data_o  out  DATA_WIDTH  data to core chain.
- bus_rw_o  out  1  rw to core chain.
- bus_valid_o  out  1  one-cycle issue pulse.
- bus_data_i  in  DATA_WIDTH  data returned from tail of chain.
- bus_valid_i  in  1  response pulse from tail of chain.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, state IDLE, last_grant = 1 (so port 0 wins the first tie), timeout counter 0.
- State machine IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - reqN_ready = 1 only for the selected port; the other port is 0.
  - Selection: if exactly one reqN_valid, select it; if both, select the port ≠ last_grant.
  - On handshake: latch addr/data/rw and grant index; set last_grant; go to ISSUE.
- ISSUE:
  - Drive bus_*_o from the latch with bus_valid_o = 1 for exactly one cycle; go to WAIT.
  - bus_addr_o, bus_data_o and bus_rw_o hold their latched values through WAIT; bus_valid_o is 0 outside ISSUE.
- WAIT:
  - Timeout counter increments each cycle.
  - Both readies are 0 in ISSUE and WAIT.
  - On bus_valid_i: registered response next cycle. rspG_valid = 1 and rspG_data = bus_data_i for granted port G; rspG_err = 0; then IDLE.
  - Writes also complete on bus_valid_i; the returned data is passed through.
  - If the counter reaches TIMEOUT_CYCLES without bus_valid_i: rspG_valid = 1, rspG_data = 0, rspG_err = 1; then IDLE.
  - bus_valid_i in the same cycle the timeout fires: the normal response wins, err = 0.
- Stray responses: bus_valid_i in IDLE or ISSUE is ignored and produces no rsp pulse.
- rsp*_err is meaningful only while rsp*_valid is high; otherwise 0.
- Minimum turnaround: handshake at cycle t, bus_valid_o at t+1. With the response at t+1+L, rsp valid is at t+2+L and the next handshake is possible at t+3+L.
- Reset mid-transaction: returns to IDLE immediately and drops the outstanding transaction. A late bus_valid_i after reset is treated as stray.

Optional Feature:
- ARB_STATS_EN defined: adds outputs grant_cnt0, grant_cnt1 and timeout_cnt, each 32 bits.
  - Each counter increments on the matching grant or timeout and wraps at 2^32.
  - All three reset to 0.
- ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single read, port 0: req0 addr 0x0005 rw 0; bench core returns 0xBEEF three cycles after bus_valid_o -> exactly one bus_valid_o with addr 0x0005; rsp0_valid with data 0xBEEF, err 0; rsp1_valid never asserts.
- Simultaneous requests: both valid from reset, req0 addr 0x0001, req1 addr 0x0002 -> bus order 0x0001 then 0x0002. Repeat the tie -> grants alternate 0, 1, 0, 1 over 4 transactions.
- Write passthrough, port 1: req1 addr 0x0010 data 0x1234 rw 1 -> bus_rw_o 1, bus_data_o 0x1234; on echo, rsp1_valid with data 0x1234.
- Timeout: TIMEOUT_CYCLES = 8, the core never responds -> rspG_valid with err 1 and data 0, eight cycles after entering WAIT; the next request proceeds normally.
- Stray response and reset abort:
  - Pulse bus_valid_i in IDLE -> no rsp pulse.
  - Assert rst_n = 0 during WAIT -> all outputs go to 0 asynchronously; after release, a new req0 completes normally.
- ARB_STATS_EN: 3 port-0 grants, 2 port-1 grants and 1 timeout -> grant_cnt0 = 3, grant_cnt1 = 2, timeout_cnt = 1.
